// File: rtl/raytracing_line_collector_pkg.sv
// Shared types and geometry for the raytracing line collector.
// Pixel colours are 4:4:4 RGB. Worker buffers arrive as one flat vector,
// worker-major and job-minor, with worker 0 job 0 in the lowest bits.
package raytracing_line_collector_pkg;

  localparam int N_WORKERS        = 8;
  localparam int JOBS_SUBDIVISION = 4;
  localparam int H_RES            = 640;
  localparam int V_RES            = 480;
  localparam int ADDR_B           = 19;
  localparam int COLOR_W          = 12;
  localparam int N_PIX            = N_WORKERS * JOBS_SUBDIVISION;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } color_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } collector_state_t;

  // Pick the colour that worker w produced for its job j out of the flat bus.
  function automatic color_t buf_color(input logic [N_PIX*COLOR_W-1:0] bufs,
                                       input int w, input int j);
    return bufs[(w*JOBS_SUBDIVISION + j)*COLOR_W +: COLOR_W];
  endfunction

endpackage

// File: rtl/raytracing_line_collector_fb_write_port_reg.sv
// Valid/ready output register towards the framebuffer write port.
// Address and data are only reloaded when the slot is empty or being
// accepted, so they stay stable while the framebuffer applies backpressure.
module fb_write_port_reg
  import raytracing_line_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_,
  input  logic              load,
  input  logic [ADDR_B-1:0] load_addr,
  input  color_t            load_data,
  output logic              load_ready,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_B-1:0] wr_addr,
  output color_t            wr_data
);

  assign load_ready = !wr_valid || wr_ready;

  // Refill the output slot whenever it is free or its write is being taken.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (load_ready) begin
      wr_valid <= load;
      if (load) begin
        wr_addr <= load_addr;
        wr_data <= load_data;
      end
    end
  end

endmodule

// File: rtl/raytracing_line_collector.sv
// Collects the colour buffers of a finished worker batch and streams them in
// ascending pixel order to the framebuffer. The buffers are snapshotted so the
// dispatcher can relaunch the workers while the previous batch drains.
module raytracing_line_collector
  import raytracing_line_collector_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         start,
  output logic                         start_ready,
  input  logic [9:0]                   batch_x,
  input  logic [8:0]                   batch_y,
  input  logic [N_WORKERS-1:0]         worker_busy,
  input  logic [N_PIX*COLOR_W-1:0]     worker_buf,
  output logic                         captured,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_B-1:0]            wr_addr,
  output color_t                       wr_data,
  output logic                         batch_done
);

  localparam int PIX_W = $clog2(N_PIX);
  localparam int K_W   = PIX_W + 1;
  localparam int COL_W = 11;

  localparam logic [K_W-1:0]    K_END      = K_W'(N_PIX);
  localparam logic [COL_W-1:0]  COL_LIMIT  = COL_W'(H_RES);
  localparam logic [8:0]        ROW_LIMIT  = 9'(V_RES);
  localparam logic [ADDR_B-1:0] ROW_STRIDE = ADDR_B'(H_RES);

  collector_state_t     state;
  logic [9:0]           batch_x_q;
  logic [ADDR_B-1:0]    row_base;
  logic                 row_ok;
  logic [N_WORKERS-1:0] seen_busy;
  logic [K_W-1:0]       k;
  color_t               snapshot [N_PIX];

  logic [COL_W-1:0]     column;
  logic                 pending;
  logic                 in_frame;
  logic                 load;
  logic                 advance;
  logic                 load_ready;
  logic [ADDR_B-1:0]    load_addr;
  color_t               load_data;

  // Offer pixel k to the write port; off-screen pixels are skipped in one cycle.
  always_comb begin
    column    = COL_W'(batch_x_q) + COL_W'(k);
    pending   = ((state == ST_CAPTURE) || (state == ST_DRAIN)) && (k != K_END);
    in_frame  = row_ok && (column < COL_LIMIT);
    load      = pending && in_frame && load_ready;
    advance   = pending && (!in_frame || load_ready);
    load_addr = row_base + ADDR_B'(column);
    load_data = snapshot[k[PIX_W-1:0]];
  end

  // Batch sequencing: wait for every worker to have run and gone idle, take the
  // snapshot on the edge into CAPTURE (so captured already means "copied"),
  // then walk the pixels and pulse batch_done once the last write is taken.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state       <= ST_IDLE;
      start_ready <= 1'b0;
      captured    <= 1'b0;
      batch_done  <= 1'b0;
      batch_x_q   <= '0;
      row_base    <= '0;
      row_ok      <= 1'b0;
      seen_busy   <= '0;
      k           <= '0;
      for (int p = 0; p < N_PIX; p++) snapshot[p] <= '0;
    end else begin
      captured   <= 1'b0;
      batch_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && start_ready) begin
            batch_x_q   <= batch_x;
            row_base    <= ADDR_B'(batch_y) * ROW_STRIDE;
            row_ok      <= (batch_y < ROW_LIMIT);
            seen_busy   <= '0;
            start_ready <= 1'b0;
            state       <= ST_ARM;
          end else begin
            start_ready <= 1'b1;
          end
        end
        ST_ARM: begin
          seen_busy <= seen_busy | worker_busy;
          if ((&seen_busy) && !(|worker_busy)) begin
            for (int p = 0; p < N_PIX; p++)
              snapshot[p] <= buf_color(worker_buf, p % N_WORKERS, p / N_WORKERS);
            captured <= 1'b1;
            k        <= '0;
            state    <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (advance) k <= k + K_W'(1);
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (advance) k <= k + K_W'(1);
          if ((k == K_END) && load_ready) begin
            batch_done <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          start_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  fb_write_port_reg u_port (
    .clk        (clk),
    .rst_       (rst_),
    .load       (load),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

endmodule
